// File: rtl/radd_pkg.sv
// radd_pkg: shared FSM state type and default geometry for the sliced adder sequencer
package radd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} radd_seq_state_e;
    localparam int RADD_WIDTH = 32;
    localparam int RADD_SLICE = 8;
endpackage

// File: rtl/radd_slice.sv
// radd_slice: combinational SLICE-bit ripple-carry adder built from per-bit full-add equations
module radd_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);
    logic [SLICE:0] w_c;
    assign w_c[0] = cin;
    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
    assign cout = w_c[SLICE];
endmodule

// File: rtl/radd_seq_ctrl.sv
// radd_seq_ctrl: sequences a WIDTH-bit add through one SLICE-bit adder, LSB slice first.
// Optional subtract mode (in_sub) is enabled by defining RADD_SEQ_SUB_EN.
module radd_seq_ctrl
    import radd_pkg::*;
#(
    parameter int WIDTH = RADD_WIDTH,
    parameter int SLICE = RADD_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef RADD_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_bad_geometry
        $error("radd_seq_ctrl: WIDTH must be a non-zero multiple of SLICE");
    end

    radd_seq_state_e              r_state, w_next;
    logic [NSLICE-1:0][SLICE-1:0] r_a, r_b, r_sum;
    logic [IW-1:0]                r_idx;
    logic                         r_carry, r_cout;
    logic [SLICE-1:0]             w_sb, w_s;
    logic                         w_co, w_last, w_accept;

`ifdef RADD_SEQ_SUB_EN
    logic r_sub;
    assign w_sb = r_b[r_idx] ^ {SLICE{r_sub}};
`else
    assign w_sb = r_b[r_idx];
`endif

    assign w_last   = (r_idx == IW'(NSLICE - 1));
    assign w_accept = (r_state == IDLE) && in_valid;

    radd_slice #(.SLICE(SLICE)) u_slice (
        .a   (r_a[r_idx]),
        .b   (w_sb),
        .cin (r_carry),
        .sum (w_s),
        .cout(w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN:  if (w_last) w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // carry register is seeded with the (possibly inverted) carry-in at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
`ifdef RADD_SEQ_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_idx   <= '0;
`ifdef RADD_SEQ_SUB_EN
            r_sub   <= in_sub;
            r_carry <= in_cin ^ in_sub;
`else
            r_carry <= in_cin;
`endif
        end else if (r_state == RUN) begin
            r_sum[r_idx] <= w_s;
            r_carry      <= w_co;
            r_idx        <= w_last ? r_idx : r_idx + IW'(1);
            if (w_last) r_cout <= w_co;
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;
endmodule

// File: tb/tb_radd_seq_ctrl.sv
// tb_radd_seq_ctrl: directed table, corner sequences and random ops against an arithmetic model
module tb_radd_seq_ctrl;
    localparam int W  = 32;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic          in_cin = 1'b0;
`ifdef RADD_SEQ_SUB_EN
    logic          in_sub = 1'b0;
`endif
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_cout;

    int n_chk = 0;
    int n_fail = 0;

    radd_seq_ctrl #(.WIDTH(W), .SLICE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
`ifdef RADD_SEQ_SUB_EN
        .in_sub   (in_sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
        logic [W:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~cin};
        else     r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return r;
    endfunction

    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input int hold,
                         input logic [W-1:0] es, input logic ec);
        int w;
        int cnt;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " ready"}, 64'(in_ready), 64'(1));
        in_a = a;
        in_b = b;
        in_cin = cin;
`ifdef RADD_SEQ_SUB_EN
        in_sub = sub;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({nm, " latency"}, 64'(cnt), 64'(NS));
        chk({nm, " sum"}, 64'(out_sum), 64'(es));
        chk({nm, " cout"}, 64'(out_cout), 64'(ec));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({nm, " held"}, {31'b0, out_valid, out_sum}, {31'b0, 1'b1, es});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " drop"}, 64'(out_valid), 64'(0));
    endtask

    vec_t vt[6];
    logic [W:0] r;

    initial begin
        vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vt[1] = '{32'h1234_5678, 32'h0000_00FF, 1'b1, 32'h1234_5778, 1'b0};
        vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vt[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vt[4] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
        vt[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};

        repeat (2) @(negedge clk);
        chk("reset state", {30'b0, in_ready, out_valid, out_cout, out_sum},
            {30'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, 1'b0, 0, vt[i].sum, vt[i].cout);

        // back-pressure with ignored in_valid pulses
        @(negedge clk);
        in_a = 32'h0000_0010; in_b = 32'h0000_0020; in_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NS) @(negedge clk);
        chk("bp valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 10; i++) begin
            in_a = 32'hDEAD_0000 + i; in_b = 32'h1111_1111; in_valid = i[0];
            @(negedge clk);
            chk($sformatf("bp hold %0d", i), {30'b0, out_valid, in_ready, out_sum},
                {30'b0, 1'b1, 1'b0, 32'h0000_0030});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp drop", 64'(out_valid), 64'(0));
        do_op("bp next", 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 0, 32'h0000_0301, 1'b0);

        // reset during the second RUN cycle
        @(negedge clk);
        in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst state", {30'b0, in_ready, out_valid, out_cout, out_sum},
            {30'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("midrst no pulse %0d", i), 64'(out_valid), 64'(0));
        end
        do_op("midrst next", 32'h1, 32'h1, 1'b0, 1'b0, 0, 32'h2, 1'b0);

        // reset and in_valid together: operand pair must be dropped
        @(negedge clk);
        in_a = 32'h5; in_b = 32'h5; in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        repeat (NS + 1) @(negedge clk);
        chk("rst wins", {62'b0, in_ready, out_valid}, {62'b0, 1'b1, 1'b0});

`ifdef RADD_SEQ_SUB_EN
        do_op("sub 5-7", 32'h5, 32'h7, 1'b0, 1'b1, 0, 32'hFFFF_FFFE, 1'b0);
        do_op("sub 7-5", 32'h7, 32'h5, 1'b0, 1'b1, 0, 32'h2, 1'b1);
        do_op("sub borrow", 32'h7, 32'h5, 1'b1, 1'b1, 0, 32'h1, 1'b1);
`endif

        for (int k = 0; k < 1000; k++) begin
            logic [W-1:0] a, b;
            logic c, s;
            a = (k % 17 == 0) ? 32'hFFFF_FFFF : $urandom;
            b = (k % 23 == 0) ? 32'hFFFF_FFFF - a : $urandom;
            c = 1'($urandom_range(0, 1));
`ifdef RADD_SEQ_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            r = ref_model(a, b, c, s);
            do_op($sformatf("rnd%0d", k), a, b, c, s, $urandom_range(0, 3), r[W-1:0], r[W]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
